// File: rtl/mips_mc_if.sv
// Memory-side bus of the multicycle MIPS core: one instruction fetch port and one data port,
// both req/ack handshakes with the request side held stable until the ack is sampled.
interface mips_mc_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_ack;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output imem_req, imem_addr,
        input  imem_data, imem_ack,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_data, imem_ack,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mips_mc.sv
// Multicycle MIPS subset core (FETCH/DECODE/EXEC/MEM/WB/HALT) with req/ack memory ports,
// a per-access ack timeout that halts with bus_err, and a retired-instruction counter.
module mips_mc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    mips_mc_if.master   bus,
    output logic        halted,
    output logic        bus_err,
    output logic [31:0] retired
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    // Count value at which the final allowed wait cycle is being spent.
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    state_t      state;
    logic [31:0] pc, ir, a, b, alu_out, mdr, wait_cnt;
    logic [31:0] rf [32];

    logic        imem_req, dmem_req, dmem_we;
    logic [31:0] imem_addr, dmem_addr, dmem_wdata;

    assign bus.imem_req   = imem_req;
    assign bus.imem_addr  = imem_addr;
    assign bus.dmem_req   = dmem_req;
    assign bus.dmem_we    = dmem_we;
    assign bus.dmem_addr  = dmem_addr;
    assign bus.dmem_wdata = dmem_wdata;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, dest;
    logic [31:0] simm, rs_val, rt_val, alu_res, next_pc;
    logic        legal, tmo;

    assign op     = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign funct  = ir[5:0];
    assign simm   = {{16{ir[15]}}, ir[15:0]};
    assign rs_val = (rs == 5'd0) ? 32'd0 : rf[rs];
    assign rt_val = (rt == 5'd0) ? 32'd0 : rf[rt];
    assign dest   = (op == OP_R) ? rd : rt;
    assign tmo    = (TIMEOUT != 0) && (wait_cnt == TMO_LAST);

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_R: legal = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                          (funct == FN_OR)  || (funct == FN_SLT);
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // Non-R ops use a+simm, which doubles as the lw/sw effective address.
    always_comb begin
        alu_res = a + simm;
        if (op == OP_R) begin
            case (funct)
                FN_SUB:  alu_res = a - b;
                FN_AND:  alu_res = a & b;
                FN_OR:   alu_res = a | b;
                FN_SLT:  alu_res = {31'd0, $signed(a) < $signed(b)};
                default: alu_res = a + b;
            endcase
        end
    end

    // pc already points past the branch, so the offset is relative to pc+4 of the branch.
    always_comb begin
        next_pc = pc;
        case (op)
            OP_BEQ:  if (a == b) next_pc = pc + {simm[29:0], 2'b00};
            OP_BNE:  if (a != b) next_pc = pc + {simm[29:0], 2'b00};
            OP_J:    next_pc = {pc[31:28], ir[25:0], 2'b00};
            default: next_pc = pc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            ir         <= '0;
            a          <= '0;
            b          <= '0;
            alu_out    <= '0;
            mdr        <= '0;
            wait_cnt   <= '0;
            retired    <= '0;
            halted     <= 1'b0;
            bus_err    <= 1'b0;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            case (state)
                FETCH: begin
                    // Only reached with req low straight out of reset; all other entries pre-arm it.
                    if (!imem_req) begin
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                        wait_cnt  <= '0;
                    end else if (bus.imem_ack) begin
                        ir       <= bus.imem_data;
                        pc       <= pc + 32'd4;
                        imem_req <= 1'b0;
                        state    <= DECODE;
                    end else if (tmo) begin
                        imem_req <= 1'b0;
                        bus_err  <= 1'b1;
                        halted   <= 1'b1;
                        state    <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                DECODE: begin
                    a <= rs_val;
                    b <= rt_val;
                    if (legal) begin
                        state <= EXEC;
                    end else begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end
                end
                EXEC: begin
                    case (op)
                        OP_LW, OP_SW: begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= (op == OP_SW);
                            dmem_addr  <= alu_res;
                            dmem_wdata <= b;
                            wait_cnt   <= '0;
                            state      <= MEM;
                        end
                        OP_BEQ, OP_BNE, OP_J: begin
                            pc        <= next_pc;
                            imem_req  <= 1'b1;
                            imem_addr <= next_pc;
                            wait_cnt  <= '0;
                            retired   <= retired + 32'd1;
                            state     <= FETCH;
                        end
                        default: begin
                            alu_out <= alu_res;
                            state   <= WB;
                        end
                    endcase
                end
                MEM: begin
                    if (bus.dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (op == OP_SW) begin
                            retired   <= retired + 32'd1;
                            imem_req  <= 1'b1;
                            imem_addr <= pc;
                            wait_cnt  <= '0;
                            state     <= FETCH;
                        end else begin
                            mdr   <= bus.dmem_rdata;
                            state <= WB;
                        end
                    end else if (tmo) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        bus_err  <= 1'b1;
                        halted   <= 1'b1;
                        state    <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                WB: begin
                    if (dest != 5'd0) rf[dest] <= (op == OP_LW) ? mdr : alu_out;
                    retired   <= retired + 32'd1;
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                    wait_cnt  <= '0;
                    state     <= FETCH;
                end
                HALT: ;
                default: begin
                    halted <= 1'b1;
                    state  <= HALT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mips_mc.sv
// Directed bench for mips_mc: table of small ALU/store programs plus hand-written sequences
// for wait states, branches, timeout, illegal opcodes and reset during a data access.
module tb_mips_mc;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_mc_if bus();
    logic        halted, bus_err;
    logic [31:0] retired;

    mips_mc #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .bus(bus.master),
        .halted(halted), .bus_err(bus_err), .retired(retired)
    );

    localparam logic [31:0] ILL = 32'hFC00_0000;

    logic [31:0] imem [256];
    logic [31:0] dmem [256];
    logic        im_ack = 1'b0, dm_ack = 1'b0, late_ack = 1'b0;
    int          im_delay = 0, dm_delay = 0, im_cnt = 0, dm_cnt = 0;

    logic [31:0] fetch_log[$];
    logic [31:0] dm_addr_log[$];
    logic [31:0] dm_ret_log[$];
    int          dm_len_log[$];
    bit          dm_unst_log[$];
    int          wr_cnt = 0;
    logic [31:0] last_waddr = '0, last_wdata = '0, a0 = '0, w0 = '0;
    logic        we0 = 1'b0;
    bit          unst = 1'b0;

    int checks = 0, errors = 0;

    assign bus.imem_ack   = im_ack;
    assign bus.imem_data  = imem[bus.imem_addr[9:2]];
    assign bus.dmem_ack   = dm_ack | late_ack;
    assign bus.dmem_rdata = dmem[bus.dmem_addr[9:2]];

    // Memory responder: ack after *_delay wait cycles; logs every completed transaction.
    always @(negedge clk) begin
        if (rst) begin
            im_ack = 1'b0; dm_ack = 1'b0; im_cnt = 0; dm_cnt = 0; wr_cnt = 0;
            fetch_log.delete(); dm_addr_log.delete(); dm_ret_log.delete();
            dm_len_log.delete(); dm_unst_log.delete();
        end else begin
            if (bus.imem_req) begin
                im_cnt++;
                im_ack = (im_cnt > im_delay);
                if (im_ack) fetch_log.push_back(bus.imem_addr);
            end else begin
                im_cnt = 0; im_ack = 1'b0;
            end
            if (bus.dmem_req) begin
                dm_cnt++;
                if (dm_cnt == 1) begin
                    a0 = bus.dmem_addr; w0 = bus.dmem_wdata; we0 = bus.dmem_we; unst = 1'b0;
                end else if (bus.dmem_addr != a0 || bus.dmem_wdata != w0 || bus.dmem_we != we0) begin
                    unst = 1'b1;
                end
                dm_ack = (dm_cnt > dm_delay);
                if (dm_ack) begin
                    dm_addr_log.push_back(bus.dmem_addr);
                    dm_ret_log.push_back(retired);
                    dm_len_log.push_back(dm_cnt);
                    dm_unst_log.push_back(unst);
                    if (bus.dmem_we) begin
                        wr_cnt++; last_waddr = bus.dmem_addr; last_wdata = bus.dmem_wdata;
                    end
                end
            end else begin
                dm_cnt = 0; dm_ack = 1'b0;
            end
        end
    end

    typedef struct packed {
        logic [3:0][31:0] prog;
        logic [31:0]      waddr;
        logic [31:0]      wdata;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] bexp [6];

    function automatic logic [31:0] ri(input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction
    function automatic logic [31:0] ii(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] jj(input logic [25:0] t);
        return {6'b000010, t};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rt, input logic [15:0] imm);
        return ii(6'b001000, 5'd0, rt, imm);
    endfunction
    function automatic logic [31:0] sw3(input logic [15:0] off);
        return ii(6'b101011, 5'd0, 5'd3, off);
    endfunction
    function automatic vec_t mk(input logic [31:0] i0, i1, i2, i3, wa, wd);
        vec_t v;
        v.prog[0] = i0; v.prog[1] = i1; v.prog[2] = i2; v.prog[3] = i3;
        v.waddr = wa; v.wdata = wd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = ILL;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_halt(input string nm, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(posedge clk); #1; n++;
        end
        chk({nm, "_halted"}, 32'(halted), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        int n, hi;
        vecs[0] = mk(addi(1, 16'd5),    addi(2, 16'd7),    ri(6'h20, 1, 2, 3), sw3(16'd0),     32'h0,        32'd12);
        vecs[1] = mk(addi(1, 16'd5),    addi(2, 16'd7),    ri(6'h22, 1, 2, 3), sw3(16'd4),     32'h4,        32'hFFFF_FFFE);
        vecs[2] = mk(addi(1, 16'h0F),   addi(2, 16'h3C),   ri(6'h24, 1, 2, 3), sw3(16'd8),     32'h8,        32'h0C);
        vecs[3] = mk(addi(1, 16'h0F),   addi(2, 16'h3C),   ri(6'h25, 1, 2, 3), sw3(16'd12),    32'hC,        32'h3F);
        vecs[4] = mk(addi(1, 16'hFFFF), addi(2, 16'd1),    ri(6'h2A, 1, 2, 3), sw3(16'd16),    32'h10,       32'd1);
        vecs[5] = mk(addi(1, 16'd1),    addi(2, 16'hFFFF), ri(6'h2A, 1, 2, 3), sw3(16'd20),    32'h14,       32'd0);
        vecs[6] = mk(addi(1, 16'hFFFF), addi(2, 16'd1),    ri(6'h20, 1, 2, 3), sw3(16'hFFFC),  32'hFFFF_FFFC, 32'd0);
        vecs[7] = mk(addi(0, 16'd9),    addi(0, 16'd9),    ri(6'h20, 0, 0, 3), sw3(16'd24),    32'h18,       32'd0);
        bexp[0] = 32'h0; bexp[1] = 32'h4; bexp[2] = 32'h100;
        bexp[3] = 32'h10; bexp[4] = 32'h10; bexp[5] = 32'h10;
        for (int i = 0; i < 256; i++) dmem[i] = 32'h0;

        // Reset values and first request.
        clear_imem();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("rst_dmem_we",  32'(bus.dmem_we),  32'd0);
        chk("rst_halted",   32'(halted),       32'd0);
        chk("rst_bus_err",  32'(bus_err),      32'd0);
        chk("rst_retired",  retired,           32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("first_imem_req",  32'(bus.imem_req), 32'd1);
        chk("first_imem_addr", bus.imem_addr,     32'h0);
        wait_halt("ill_only", 50);
        chk("ill_only_bus_err", 32'(bus_err), 32'd0);
        chk("ill_only_retired", retired,      32'd0);
        chk("ill_only_imem_req", 32'(bus.imem_req), 32'd0);

        // Table: four-instruction programs ending in a store, then an illegal opcode.
        for (int k = 0; k < 8; k++) begin
            clear_imem();
            for (int j = 0; j < 4; j++) imem[j] = vecs[k].prog[j];
            im_delay = 0; dm_delay = 0;
            do_reset();
            wait_halt($sformatf("v%0d", k), 300);
            chk($sformatf("v%0d_bus_err", k), 32'(bus_err), 32'd0);
            chk($sformatf("v%0d_retired", k), retired,      32'd4);
            chk($sformatf("v%0d_wr_cnt", k),  32'(wr_cnt),  32'd1);
            chk($sformatf("v%0d_waddr", k),   last_waddr,   vecs[k].waddr);
            chk($sformatf("v%0d_wdata", k),   last_wdata,   vecs[k].wdata);
        end

        // lw with 3 wait cycles, result observed through a following sw.
        clear_imem();
        imem[0] = ii(6'b100011, 5'd0, 5'd5, 16'd8);
        imem[1] = ii(6'b101011, 5'd0, 5'd5, 16'd4);
        dmem[2] = 32'hDEAD_BEEF;
        im_delay = 0; dm_delay = 3;
        do_reset();
        wait_halt("lw", 300);
        chk("lw_n_access", 32'(dm_len_log.size()), 32'd2);
        chk("lw_req_len",  32'((dm_len_log.size() > 0) ? dm_len_log[0] : -1), 32'd4);
        chk("lw_stable",   32'((dm_unst_log.size() > 0) ? dm_unst_log[0] : 1'b1), 32'd0);
        chk("lw_addr",     (dm_addr_log.size() > 0) ? dm_addr_log[0] : 32'hDEAD_DEAD, 32'h8);
        chk("lw_ret_after", (dm_ret_log.size() > 1) ? dm_ret_log[1] : 32'hDEAD_DEAD, 32'd1);
        chk("lw_wdata",    last_wdata, 32'hDEAD_BEEF);
        chk("lw_waddr",    last_waddr, 32'h4);
        chk("lw_retired",  retired,    32'd2);
        chk("lw_bus_err",  32'(bus_err), 32'd0);

        // Branch/jump fetch sequence.
        clear_imem();
        imem[0]  = ii(6'b000101, 5'd0, 5'd0, 16'd5);
        imem[1]  = jj(26'h40);
        imem[64] = jj(26'h4);
        imem[4]  = ii(6'b000100, 5'd0, 5'd0, 16'hFFFF);
        im_delay = 0; dm_delay = 0;
        do_reset();
        n = 0;
        while (fetch_log.size() < 6 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        for (int j = 0; j < 6; j++)
            chk($sformatf("br_fetch%0d", j), (j < fetch_log.size()) ? fetch_log[j] : 32'hDEAD_DEAD, bexp[j]);
        chk("br_retired", retired,       32'd5);
        chk("br_halted",  32'(halted),   32'd0);

        // Fetch timeout: ack never comes.
        clear_imem();
        im_delay = 100000;
        do_reset();
        n = 0; hi = 0;
        while (!halted && n < 50) begin
            @(posedge clk); #1; n++;
            if (bus.imem_req) hi++;
        end
        chk("tmo_halted",   32'(halted),       32'd1);
        chk("tmo_bus_err",  32'(bus_err),      32'd1);
        chk("tmo_imem_req", 32'(bus.imem_req), 32'd0);
        chk("tmo_req_len",  32'(hi),           32'd4);
        chk("tmo_retired",  retired,           32'd0);

        // Ack on the very cycle the wait count reaches the limit must win.
        clear_imem();
        imem[0] = addi(1, 16'd3);
        imem[1] = ii(6'b101011, 5'd0, 5'd1, 16'd0);
        im_delay = 3; dm_delay = 3;
        do_reset();
        wait_halt("win", 400);
        chk("win_bus_err", 32'(bus_err), 32'd0);
        chk("win_retired", retired,      32'd2);
        chk("win_wdata",   last_wdata,   32'd3);

        // Reset in the middle of a data wait, then a stray ack after reset.
        clear_imem();
        imem[0] = ii(6'b100011, 5'd0, 5'd4, 16'd0);
        dmem[0] = 32'h0000_1234;
        im_delay = 0; dm_delay = 100000;
        do_reset();
        n = 0;
        while (!bus.dmem_req && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("mid_reached_mem", 32'(bus.dmem_req), 32'd1);
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_dmem_req_drop", 32'(bus.dmem_req), 32'd0);
        chk("mid_retired_clr",   retired,           32'd0);
        clear_imem();
        imem[0] = ii(6'b101011, 5'd0, 5'd4, 16'd12);
        dm_delay = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        late_ack = 1'b1;
        @(negedge clk);
        late_ack = 1'b0;
        wait_halt("mid", 200);
        chk("mid_first_fetch", (fetch_log.size() > 0) ? fetch_log[0] : 32'hDEAD_DEAD, 32'h0);
        chk("mid_wr_cnt",  32'(wr_cnt), 32'd1);
        chk("mid_waddr",   last_waddr,  32'd12);
        chk("mid_wdata",   last_wdata,  32'd0);
        chk("mid_retired", retired,     32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_mc.md
MIPS_MC -- requirements
Module: mips_mc

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 The block SHALL have parameter TIMEOUT, default 16: maximum wait cycles for a memory ack; 0 disables the timeout.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 imem_req / imem_addr  output  1 / 32  instruction fetch request and word address.
REQ-007 imem_data / imem_ack  input  32 / 1  fetched instruction and its completion strobe.
REQ-008 dmem_req / dmem_we  output  1 / 1  data access request and write enable.
REQ-009 dmem_addr / dmem_wdata  output  32 / 32  data address and store data.
REQ-010 dmem_rdata / dmem_ack  input  32 / 1  load data and access completion strobe.
REQ-011 halted  output  1  core stopped (sticky until reset).
REQ-012 bus_err  output  1  halt caused by memory timeout.
REQ-013 retired  output  32  count of completed instructions.

Function
REQ-014 The core SHALL be multicycle, with FSM states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-015 Supported instructions: R-type funct add 100000, sub 100010, and 100100, or 100101, slt 101010 (signed); lw 100011; sw 101011; beq 000100; bne 000101; addi 001000 (sign-extended immediate); j 000010.
REQ-016 FETCH: drive imem_req=1 and imem_addr=pc; on imem_ack, latch IR=imem_data, set pc=pc+4, go to DECODE.
REQ-017 DECODE: latch A=reg[rs] and B=reg[rt]; an unknown opcode or an unknown R-type funct goes to HALT with bus_err=0; otherwise go to EXEC.
REQ-018 EXEC, R-type/addi: latch the ALU result, go to WB.
REQ-019 EXEC, lw/sw: latch address A+sext(imm), go to MEM.
REQ-020 EXEC, beq/bne: if taken, pc=pc+(sext(imm)<<2), using pc already incremented; go to FETCH.
REQ-021 EXEC, j: pc={pc[31:28],imm26,2'b00}; go to FETCH.
REQ-022 MEM: drive dmem_req=1, dmem_addr, and dmem_we=1 for sw with dmem_wdata=B; on dmem_ack, sw goes to FETCH; lw latches dmem_rdata and goes to WB.
REQ-023 WB: write reg[rd] (R-type) or reg[rt] (addi/lw), then go to FETCH; a write to reg 0 SHALL be discarded, and reg 0 SHALL always read 0.
REQ-024 Request signals, address and wdata SHALL remain stable from the first request cycle until the cycle the ack is sampled; req SHALL deassert in the cycle after the ack.
REQ-025 An ack arriving while the matching req is low SHALL be ignored.
REQ-026 Address arithmetic SHALL wrap modulo 2^32; ALU add/sub SHALL wrap with no overflow trap.
REQ-027 retired SHALL increment by 1 at each completion (WB exit, sw ack, branch/jump EXEC exit), and SHALL wrap at 2^32.
REQ-028 Wait counter: reset on entry to FETCH/MEM and incremented each cycle waiting for ack; when TIMEOUT!=0 and the count reaches TIMEOUT without ack, go to HALT with bus_err=1 and deassert req.
REQ-029 If ack arrives in the same cycle the count reaches TIMEOUT, the ack SHALL win.
REQ-030 HALT: all reqs=0, halted=1, pc/regs/retired frozen; exit only by reset.

Reset
REQ-031 While rst=1 (asynchronously): state=FETCH, pc=RESET_PC, IR=0, all 32 registers=0, retired=0, halted=0, bus_err=0, imem_req=0, dmem_req=0, dmem_we=0, wait counter=0.
REQ-032 The first imem_req SHALL assert in the first cycle after rst deasserts.
REQ-033 Reset mid-transaction SHALL drop req immediately, and any later ack for that transaction SHALL be ignored.

Verification
REQ-034 Zero-wait ack, program: addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,0($0) -> dmem write addr 0 data 12; retired=4.
REQ-035 lw with 3-cycle dmem_ack delay -> req/addr held stable for 4 cycles, loaded value lands in rt, retired increments once.
REQ-036 beq $0,$0,-1 at 0x10 -> next fetch address 0x10; bne $0,$0,x -> next fetch 0x14; j 0x40 -> fetch 0x100.
REQ-037 TIMEOUT=4 with imem_ack never asserted -> HALT after 4 wait cycles, bus_err=1, halted=1, imem_req=0.
REQ-038 Opcode 6'b111111 -> halted=1, bus_err=0, retired unchanged; addi $0,$0,9 -> reg 0 stays 0.
REQ-039 rst asserted during a MEM wait -> dmem_req low the same cycle, pc=RESET_PC; a late ack causes no register write.
